pio_mem_rd_sched: RTL and testbench

Read scheduler that shares the single application read port of a PIO-accessible memory among NREQ application requesters. It arbitrates round-robin, issues at most one read per cycle, and tracks outstanding reads in an in-order tag FIFO. Each returning memory acknowledge is routed, with its data, to the requester that issued the read. It sits between datapath clients and the memory's app_mem_rd/app_mem_ack port; PIO register traffic to the memory is unaffected.

---
 rtl/pio_mem_rd_sched.sv | 105 ++++++++++
 tb/tb_pio_mem_rd_sched.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_mem_rd_sched.sv
// Round-robin read scheduler sharing one memory read port among NREQ requesters.
// Outstanding reads carry their requester index in an in-order tag FIFO so acks route back.
module pio_mem_rd_sched #(
   parameter int WIDTH       = 20,
   parameter int DEPTH_NBITS = 1,
   parameter int NREQ        = 4,
   parameter int MAX_OUT     = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        arb_en,
   input  logic [NREQ-1:0]             req_valid,
   input  logic [NREQ*DEPTH_NBITS-1:0] req_addr,
   output logic [NREQ-1:0]             req_ready,
   output logic                        app_mem_rd,
   output logic [DEPTH_NBITS-1:0]      app_mem_raddr,
   input  logic                        app_mem_ack,
   input  logic [WIDTH-1:0]            app_mem_rdata,
   output logic [NREQ-1:0]             rsp_valid,
   output logic [WIDTH-1:0]            rsp_data,
   output logic                        busy,
   output logic                        err_unexp_ack
);

   localparam int PW = $clog2(NREQ);
   localparam int TW = $clog2(MAX_OUT);
   localparam int CW = $clog2(MAX_OUT + 1);

   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] gidx;
   logic [PW-1:0] rr_next;
   logic          grant;
   logic [CW-1:0] out_cnt;
   logic [CW-1:0] cnt_next;
   logic [TW:0]   wr_ptr;
   logic [TW:0]   rd_ptr;
   logic [PW-1:0] tag_mem [MAX_OUT];
   logic          fifo_empty;
   logic          pop;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign pop        = app_mem_ack && !fifo_empty;
   assign rr_next    = (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;

   // Grant looks only at the current out_cnt, so a same-cycle ack never frees a slot early.
   always_comb begin
      int idx;
      idx       = 0;
      grant     = 1'b0;
      gidx      = '0;
      req_ready = '0;
      if (!rst && arb_en && (out_cnt != CW'(MAX_OUT))) begin
         for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!grant && req_valid[idx]) begin
               grant = 1'b1;
               gidx  = PW'(idx);
            end
         end
      end
      if (grant) req_ready[gidx] = 1'b1;
   end

   always_comb begin
      cnt_next = out_cnt;
      if (grant && !pop) cnt_next = out_cnt + 1'b1;
      else if (!grant && pop) cnt_next = out_cnt - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr        <= '0;
         out_cnt       <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         app_mem_rd    <= 1'b0;
         app_mem_raddr <= '0;
         rsp_valid     <= '0;
         rsp_data      <= '0;
         busy          <= 1'b0;
         err_unexp_ack <= 1'b0;
         for (int i = 0; i < MAX_OUT; i++) tag_mem[i] <= '0;
      end else begin
         app_mem_rd <= grant;
         if (grant) begin
            app_mem_raddr            <= req_addr[int'(gidx)*DEPTH_NBITS +: DEPTH_NBITS];
            tag_mem[wr_ptr[TW-1:0]] <= gidx;
            wr_ptr                   <= wr_ptr + 1'b1;
            rr_ptr                   <= rr_next;
         end
         rsp_valid <= '0;
         if (pop) begin
            rsp_valid[tag_mem[rd_ptr[TW-1:0]]] <= 1'b1;
            rsp_data                            <= app_mem_rdata;
            rd_ptr                              <= rd_ptr + 1'b1;
         end
         // An ack with nothing outstanding is dropped and only flagged.
         if (app_mem_ack && fifo_empty) err_unexp_ack <= 1'b1;
         out_cnt <= cnt_next;
         busy    <= (out_cnt != '0);
      end
   end

endmodule

// File: tb/tb_pio_mem_rd_sched.sv
// Bench for pio_mem_rd_sched: arbiter reference model, in-order memory model with a
// configurable latency, and scoreboard queues for read strobes and routed responses.
module tb_pio_mem_rd_sched;
   localparam int WIDTH       = 20;
   localparam int DEPTH_NBITS = 1;
   localparam int NREQ        = 4;
   localparam int MAX_OUT     = 4;
   localparam int LAT         = 3;

   logic                        clk = 1'b0;
   logic                        rst;
   logic                        arb_en;
   logic [NREQ-1:0]             req_valid;
   logic [NREQ*DEPTH_NBITS-1:0] req_addr;
   logic [NREQ-1:0]             req_ready;
   logic                        app_mem_rd;
   logic [DEPTH_NBITS-1:0]      app_mem_raddr;
   logic                        app_mem_ack;
   logic [WIDTH-1:0]            app_mem_rdata;
   logic [NREQ-1:0]             rsp_valid;
   logic [WIDTH-1:0]            rsp_data;
   logic                        busy;
   logic                        err_unexp_ack;

   pio_mem_rd_sched #(
      .WIDTH       (WIDTH),
      .DEPTH_NBITS (DEPTH_NBITS),
      .NREQ        (NREQ),
      .MAX_OUT     (MAX_OUT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .arb_en        (arb_en),
      .req_valid     (req_valid),
      .req_addr      (req_addr),
      .req_ready     (req_ready),
      .app_mem_rd    (app_mem_rd),
      .app_mem_raddr (app_mem_raddr),
      .app_mem_ack   (app_mem_ack),
      .app_mem_rdata (app_mem_rdata),
      .rsp_valid     (rsp_valid),
      .rsp_data      (rsp_data),
      .busy          (busy),
      .err_unexp_ack (err_unexp_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      int                     due;
      logic [DEPTH_NBITS-1:0] addr;
   } rd_t;
   typedef struct {
      int               due;
      int               tag;
      logic [WIDTH-1:0] data;
   } rsp_t;

   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   rr = 0;
   int   last_cnt = 0;
   logic exp_err = 1'b0;
   logic mem_hold = 1'b0;
   logic release_one = 1'b0;
   logic force_ack = 1'b0;
   logic fix_en = 1'b0;
   logic [WIDTH-1:0] fix_data = '0;
   logic [WIDTH-1:0] last_rsp_data = '0;

   int   out_tags[$];
   int   mem_pend[$];
   int   grant_log[$];
   rd_t  rd_q[$];
   rsp_t rsp_q[$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   // One clock cycle: drive memory, check registered outputs and the arbiter, update model.
   task automatic tick();
      int               cur;
      int               g;
      int               idx;
      logic             ack;
      logic [WIDTH-1:0] d;
      logic [NREQ-1:0]  exp_ready;
      rd_t              r;
      rsp_t             s;
      cur = out_tags.size();
      d   = fix_en ? fix_data : WIDTH'($urandom);
      ack = 1'b0;
      if (!rst) begin
         if (force_ack) ack = 1'b1;
         else if (mem_pend.size() > 0 && mem_pend[0] <= cyc && (!mem_hold || release_one)) begin
            ack = 1'b1;
            void'(mem_pend.pop_front());
            release_one = 1'b0;
         end
      end
      app_mem_ack   = ack;
      app_mem_rdata = d;
      #1;
      check_eq("busy", busy, last_cnt != 0);
      check_eq("err_unexp_ack", err_unexp_ack, exp_err);
      if (rsp_valid !== '0) begin
         if (rsp_q.size() == 0) check_eq("rsp_spurious", rsp_valid, 0);
         else begin
            s = rsp_q.pop_front();
            check_eq("rsp_cycle", cyc, s.due);
            check_eq("rsp_valid", rsp_valid, 32'd1 << s.tag);
            check_eq("rsp_data", rsp_data, s.data);
            last_rsp_data = rsp_data;
         end
      end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
         s = rsp_q.pop_front();
         check_eq("rsp_missing", rsp_valid, 32'd1 << s.tag);
      end
      if (app_mem_rd === 1'b1) begin
         if (rd_q.size() == 0) check_eq("rd_spurious", app_mem_rd, 0);
         else begin
            r = rd_q.pop_front();
            check_eq("rd_cycle", cyc, r.due);
            check_eq("rd_addr", app_mem_raddr, r.addr);
         end
         mem_pend.push_back(cyc + LAT);
      end else if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
         void'(rd_q.pop_front());
         check_eq("rd_missing", app_mem_rd, 1);
      end
      exp_ready = '0;
      g = -1;
      if (!rst && arb_en && cur != MAX_OUT) begin
         for (int k = 0; k < NREQ; k++) begin
            idx = (rr + k) % NREQ;
            if (g < 0 && req_valid[idx]) g = idx;
         end
      end
      if (g >= 0) exp_ready[g] = 1'b1;
      check_eq("req_ready", req_ready, exp_ready);
      for (int i = 0; i < NREQ; i++)
         if (req_valid[i] && req_ready[i]) grant_log.push_back(i);
      if (rst) begin
         out_tags.delete();
         mem_pend.delete();
         rd_q.delete();
         rsp_q.delete();
         rr      = 0;
         exp_err = 1'b0;
         cur     = 0;
      end else begin
         if (ack) begin
            if (out_tags.size() == 0) exp_err = 1'b1;
            else begin
               s.due  = cyc + 1;
               s.tag  = out_tags.pop_front();
               s.data = d;
               rsp_q.push_back(s);
            end
         end
         if (g >= 0) begin
            out_tags.push_back(g);
            r.due  = cyc + 1;
            r.addr = req_addr[g*DEPTH_NBITS +: DEPTH_NBITS];
            rd_q.push_back(r);
            rr = (g + 1) % NREQ;
         end
      end
      last_cnt = cur;
      @(negedge clk);
      cyc++;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((out_tags.size() != 0 || rsp_q.size() != 0 || rd_q.size() != 0) && n < 60) begin
         tick();
         n++;
      end
      if (n >= 60) check_eq("drain_timeout", out_tags.size(), 0);
      repeat (2) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      grant_log.delete();
   endtask

   initial begin
      int n;
      rst         = 1'b1;
      arb_en      = 1'b1;
      req_valid   = 4'b1111;
      req_addr    = '0;
      app_mem_ack = 1'b0;
      app_mem_rdata = '0;
      repeat (2) @(negedge clk);
      #1;
      check_eq("reset_req_ready", req_ready, 0);
      check_eq("reset_rd", app_mem_rd, 0);
      check_eq("reset_raddr", app_mem_raddr, 0);
      check_eq("reset_rsp_valid", rsp_valid, 0);
      check_eq("reset_rsp_data", rsp_data, 0);
      check_eq("reset_busy", busy, 0);
      check_eq("reset_err", err_unexp_ack, 0);
      req_valid = '0;
      rst       = 1'b0;
      @(negedge clk);

      // Single request from requester 2, address 1, fixed data.
      fix_en    = 1'b1;
      fix_data  = 20'hABCDE;
      req_valid = 4'b0100;
      req_addr  = 4'b0100;
      tick();
      req_valid = '0;
      drain();
      fix_en = 1'b0;
      check_eq("single_data", last_rsp_data, 20'hABCDE);
      check_eq("single_grant", grant_log[0], 2);

      // Round-robin fairness with all requesters active.
      do_reset();
      req_valid = 4'b1111;
      req_addr  = 4'b1010;
      n = 0;
      while (grant_log.size() < 8 && n < 40) begin
         tick();
         n++;
      end
      req_valid = '0;
      drain();
      check_eq("rr_count", grant_log.size(), 8);
      for (int k = 0; k < 8 && k < grant_log.size(); k++)
         check_eq("rr_order", grant_log[k], k % NREQ);

      // Backpressure at MAX_OUT, then FIFO wrap-around.
      do_reset();
      mem_hold  = 1'b1;
      req_valid = 4'b0001;
      req_addr  = 4'b0001;
      repeat (8) tick();
      check_eq("bp_grants", grant_log.size(), MAX_OUT);
      #1;
      check_eq("bp_blocked", req_ready, 0);
      release_one = 1'b1;
      tick();
      check_eq("bp_same_cycle_blocked", grant_log.size(), MAX_OUT);
      tick();
      check_eq("bp_regrant", grant_log.size(), MAX_OUT + 1);
      mem_hold = 1'b0;
      n = 0;
      while (grant_log.size() < 25 && n < 200) begin
         req_addr = 4'($urandom);
         tick();
         n++;
      end
      req_valid = '0;
      drain();
      check_eq("bp_total", grant_log.size(), 25);

      // arb_en gating with two reads in flight.
      do_reset();
      req_valid = 4'b0011;
      req_addr  = 4'b0010;
      repeat (2) tick();
      arb_en    = 1'b0;
      req_valid = 4'b1111;
      repeat (10) tick();
      check_eq("gate_grants", grant_log.size(), 2);
      check_eq("gate_busy", busy, 0);
      arb_en = 1'b1;
      tick();
      req_valid = '0;
      check_eq("gate_resume", grant_log.size() > 2 ? grant_log[2] : -1, 2);
      drain();

      // Unexpected ack with nothing outstanding.
      do_reset();
      force_ack = 1'b1;
      tick();
      force_ack = 1'b0;
      check_eq("unexp_err", err_unexp_ack, 1);
      check_eq("unexp_rsp", rsp_valid, 0);
      check_eq("unexp_busy", busy, 0);
      repeat (3) tick();
      check_eq("unexp_sticky", err_unexp_ack, 1);
      do_reset();
      check_eq("unexp_cleared", err_unexp_ack, 0);

      // Reset with three reads outstanding.
      mem_hold  = 1'b1;
      req_valid = 4'b0111;
      req_addr  = 4'b0101;
      repeat (3) tick();
      req_valid = '0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("mid_rd", app_mem_rd, 0);
      check_eq("mid_raddr", app_mem_raddr, 0);
      check_eq("mid_rsp_valid", rsp_valid, 0);
      check_eq("mid_rsp_data", rsp_data, 0);
      check_eq("mid_busy", busy, 0);
      check_eq("mid_err", err_unexp_ack, 0);
      mem_hold  = 1'b0;
      grant_log.delete();
      fix_en    = 1'b1;
      fix_data  = 20'h13579;
      req_valid = 4'b1000;
      req_addr  = 4'b1000;
      tick();
      req_valid = '0;
      drain();
      check_eq("mid_after_grant", grant_log.size() > 0 ? grant_log[0] : -1, 3);
      check_eq("mid_after_data", last_rsp_data, 20'h13579);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
